// File: rtl/div_iter_unit.sv
// Restoring radix-2 divider for RV64 DIV/DIVU/REM/REMU (+W). Option: DIV_EARLY_OUT_EN.
// Latency N+2 (N=64, or 32 for W ops); in_ready only in IDLE, result held until out_ready.
module div_iter_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic is_rem;
    logic word;
    logic q_neg;
    logic r_neg;
    logic div_zero;
    logic ovf;
  } meta_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  dvd_raw;
  meta_t            meta;

  // request decode; rem > remu > div > divu
  logic            sel_rem, sel_signed, s1, s2, accept, in_zero, in_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic [CNT_W-1:0] cnt_last;

  always_comb begin
    sel_rem    = op[3] | op[2];
    sel_signed = op[3] | (~op[2] & op[1]);
    s1 = sel_signed & (word ? src1[31] : src1[XLEN-1]);
    s2 = sel_signed & (word ? src2[31] : src2[XLEN-1]);
    if (word) begin
      a_ext = {{(XLEN-32){sel_signed & src1[31]}}, src1[31:0]};
      b_ext = {{(XLEN-32){sel_signed & src2[31]}}, src2[31:0]};
    end else begin
      a_ext = src1;
      b_ext = src2;
    end
    a_abs   = s1 ? -a_ext : a_ext;
    b_abs   = s2 ? -b_ext : b_ext;
    in_zero = word ? (src2[31:0] == 32'd0) : (src2 == '0);
    in_ovf  = sel_signed & (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                                 : (src1 == MIN_D && src2 == '1));
    accept  = in_valid & in_ready & (|op) & ~flush;
    cnt_last = meta.word ? CNT_W'(31) : CNT_W'(XLEN-1);
  end

  // one restoring step: shift in the next dividend bit, subtract if it fits
  logic [XLEN+1:0] rem_sh, diff;
  logic            step_ok;

  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    diff    = rem_sh - {2'b00, dvs};
    step_ok = ~diff[XLEN+1];
  end

  logic [XLEN-1:0] q_mag, q_val, r_val, fix_res, fix_out;

  always_comb begin
    q_mag = meta.word ? {{(XLEN-32){1'b0}}, quo[31:0]} : quo;
    q_val = meta.q_neg ? -q_mag : q_mag;
    r_val = meta.r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (meta.div_zero)
      fix_res = meta.is_rem ? dvd_raw : '1;
    else if (meta.ovf)
      fix_res = meta.is_rem ? '0 : dvd_raw;
    else
      fix_res = meta.is_rem ? r_val : q_val;
    fix_out = meta.word ? {{(XLEN-32){fix_res[31]}}, fix_res[31:0]} : fix_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      meta    <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            // W ops sit in the top half so the step always takes quo's msb
            quo     <= word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
            dvs     <= b_abs;
            dvd_raw <= a_ext;
            meta    <= '{is_rem: sel_rem, word: word, q_neg: s1 ^ s2, r_neg: s1,
                         div_zero: in_zero, ovf: in_ovf};
`ifdef DIV_EARLY_OUT_EN
            state   <= (in_zero | in_ovf) ? S_FIX : S_CALC;
`else
            state   <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          rem <= step_ok ? diff[XLEN:0] : rem_sh[XLEN:0];
          quo <= {quo[XLEN-2:0], step_ok};
          cnt <= cnt + CNT_W'(1);
          if (cnt == cnt_last) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_out;
          state  <= S_DONE;
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule
